// File: rtl/ram_serial_tx_if.sv
// Host-side bundle of the serial transmitter: start request, RAM read port and line status.
// The slave modport belongs to the transmitter; the master modport belongs to whatever drives it.
interface ram_serial_tx_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              send;
  logic [ADDR_W:0]   word_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              serial_out;
  logic              busy;
  logic              done;

  modport slave (
    input  send, word_count, rd_data,
    output rd_en, rd_addr, serial_out, busy, done
  );

  modport master (
    output send, word_count, rd_data,
    input  rd_en, rd_addr, serial_out, busy, done
  );
endinterface

// File: rtl/ram_serial_tx.sv
// Reads words 0..count-1 from the sample RAM and sends each one as a start/LSB-first/stop
// frame on serial_out. Every output comes straight from a register.
module ram_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int CLKS_PER_BIT = 13
) (
  input  logic            clk,
  input  logic            reset,
  ram_serial_tx_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  // A request larger than the RAM is limited to one full pass, so the address never wraps.
  function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c);
    return (c > MAX_WORDS) ? MAX_WORDS : c;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              line_d;

  logic              rd_en_q, busy_q, done_q, serial_q;
  logic [ADDR_W-1:0] rd_addr_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    line_d    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          count_d   = sat_count(bus.word_count);
          idx_d     = '0;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = (bus.word_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d   = bus.rd_data;
        clk_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if ((idx_q + 1'b1) < count_q) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line level is decided from the next state so serial_out can be a plain register.
    case (state_d)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      serial_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rd_en_q   <= (state_d == S_FETCH);
      rd_addr_q <= idx_d[ADDR_W-1:0];
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      serial_q  <= line_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.serial_out = serial_q;

endmodule

// File: tb/tb_ram_serial_tx.sv
// Bench for ram_serial_tx: RAM model, line decoder feeding a byte scoreboard, and cycle-exact
// checks of read strobes, frame edges and the done pulse.
module tb_ram_serial_tx;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CPB    = 4;
  localparam int WORD_T = 10 * CPB + 2;
  localparam int LOG_N  = 128;

  logic clk;
  logic reset;

  ram_serial_tx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_serial_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] exp_q [$];

  logic        line_log  [0:LOG_N-1];
  logic        rden_log  [0:LOG_N-1];
  logic        busy_log  [0:LOG_N-1];
  logic [7:0]  addr_log  [0:LOG_N-1];

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line decoder: samples each bit mid-cell, abandons a frame if reset is seen.
  always begin : mon
    logic              ok;
    logic [DATA_W-1:0] data;
    int                n;
    @(negedge clk);
    if (!reset && bus.serial_out === 1'b0) begin
      ok   = 1'b1;
      data = '0;
      for (int k = 0; k < DATA_W + 2 && ok; k++) begin
        n = (k == 0) ? CPB / 2 : CPB;
        for (int j = 0; j < n && ok; j++) begin
          @(negedge clk);
          if (reset) ok = 1'b0;
        end
        if (ok) begin
          if (k == 0)            check("start_bit", bus.serial_out, 0);
          else if (k <= DATA_W)  data[k-1] = bus.serial_out;
          else                   check("stop_bit", bus.serial_out, 1);
        end
      end
      if (ok) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("frame_data", data, exp_q.pop_front());
      end
    end
  end

  task automatic run_xfer(input int cnt, input bit ping, input int max_cyc,
                          output int done_t, output int n_done, output int n_rden,
                          output int n_low, output int max_addr);
    int t;
    int exp_n;
    exp_n = (cnt > 256) ? 256 : cnt;
    for (int i = 0; i < exp_n; i++) exp_q.push_back(mem[i]);
    done_t = -1; n_done = 0; n_rden = 0; n_low = 0; max_addr = 0;
    bus.word_count = 9'(cnt);
    bus.send = 1'b1;
    step();
    bus.send = 1'b0;
    t = 1;
    forever begin
      if (t < LOG_N) begin
        line_log[t] = bus.serial_out;
        rden_log[t] = bus.rd_en;
        busy_log[t] = bus.busy;
        addr_log[t] = bus.rd_addr;
      end
      if (bus.done) begin
        n_done++;
        if (done_t < 0) done_t = t;
      end
      if (bus.rd_en) begin
        n_rden++;
        if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
      end
      if (!bus.serial_out) n_low++;
      if (!bus.busy) break;
      if (t >= max_cyc) begin
        check("xfer_busy_timeout", bus.busy, 0);
        break;
      end
      if (ping && (t % 9 == 4)) begin
        bus.send = 1'b1;
        bus.word_count = 9'd5;
      end else begin
        bus.send = 1'b0;
      end
      step();
      t++;
    end
    bus.send = 1'b0;
  endtask

  initial begin
    int done_t, n_done, n_rden, n_low, max_addr;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    bus.rd_data    = '0;
    bus.word_count = 9'd1;
    bus.send       = 1'b1;
    reset          = 1'b1;

    // Reset held with send high: nothing may start.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_line", bus.serial_out, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rden", bus.rd_en, 0);
    end
    check("rst_addr", bus.rd_addr, 0);
    bus.send = 1'b0;
    reset    = 1'b0;
    step();
    check("post_rst_busy", bus.busy, 0);

    // Single word 0xA5.
    mem[0] = 8'hA5;
    run_xfer(1, 1'b0, 200, done_t, n_done, n_rden, n_low, max_addr);
    check("w1_rden_t1", rden_log[1], 1);
    check("w1_addr_t1", addr_log[1], 0);
    check("w1_busy_t1", busy_log[1], 1);
    check("w1_line_t2", line_log[2], 1);
    check("w1_start_t3", line_log[3], 0);
    check("w1_start_t6", line_log[6], 0);
    check("w1_bit0_t7", line_log[7], 1);
    check("w1_bit1_t11", line_log[11], 0);
    check("w1_bit7_t38", line_log[38], 1);
    check("w1_stop_t39", line_log[39], 1);
    check("w1_low_cycles", n_low, 4 + 4 * 4);
    check("w1_done_t", done_t, 1 + WORD_T);
    check("w1_done_n", n_done, 1);
    check("w1_rden_n", n_rden, 1);
    check("w1_busy_after", busy_log[2 + WORD_T], 0);

    // Two words back to back, sent in the cycle right after the previous done.
    mem[0] = 8'h3C;
    mem[1] = 8'hFF;
    run_xfer(2, 1'b0, 200, done_t, n_done, n_rden, n_low, max_addr);
    check("w2_rden_t1", rden_log[1], 1);
    check("w2_stop_end", line_log[42], 1);
    check("w2_rden_t42", rden_log[42], 0);
    check("w2_rden_t43", rden_log[43], 1);
    check("w2_addr_t43", addr_log[43], 1);
    check("w2_gap_t43", line_log[43], 1);
    check("w2_gap_t44", line_log[44], 1);
    check("w2_start_t45", line_log[45], 0);
    check("w2_done_t", done_t, 1 + 2 * WORD_T);
    check("w2_rden_n", n_rden, 2);

    // Zero words.
    run_xfer(0, 1'b0, 20, done_t, n_done, n_rden, n_low, max_addr);
    check("w0_done_t", done_t, 1);
    check("w0_busy_t1", busy_log[1], 1);
    check("w0_busy_t2", busy_log[2], 0);
    check("w0_rden_n", n_rden, 0);
    check("w0_low", n_low, 0);

    // Repeated send with a different count while busy must be dropped.
    mem[0] = 8'h5A;
    run_xfer(1, 1'b1, 200, done_t, n_done, n_rden, n_low, max_addr);
    check("ign_done_t", done_t, 1 + WORD_T);
    check("ign_done_n", n_done, 1);
    check("ign_rden_n", n_rden, 1);
    step();
    step();
    check("ign_idle", bus.busy, 0);

    // Oversized count is limited to the full RAM.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h6B);
    run_xfer(300, 1'b0, 12000, done_t, n_done, n_rden, n_low, max_addr);
    check("sat_rden_n", n_rden, 256);
    check("sat_max_addr", max_addr, 255);
    check("sat_done_t", done_t, 1 + 256 * WORD_T);

    // Reset during the data bits of word 0 of a three-word transfer.
    bus.word_count = 9'd3;
    bus.send = 1'b1;
    step();
    bus.send = 1'b0;
    for (int t = 1; t < 20; t++) step();
    check("mid_busy_before", bus.busy, 1);
    reset = 1'b1;
    step();
    check("mid_rst_line", bus.serial_out, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_rden", bus.rd_en, 0);
    reset = 1'b0;
    n_done = 0;
    n_low  = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.done) n_done++;
      if (!bus.serial_out) n_low++;
    end
    check("mid_no_done", n_done, 0);
    check("mid_line_idle", n_low, 0);
    mem[0] = 8'h96;
    run_xfer(1, 1'b0, 200, done_t, n_done, n_rden, n_low, max_addr);
    check("restart_rden", rden_log[1], 1);
    check("restart_addr", addr_log[1], 0);
    check("restart_done_t", done_t, 1 + WORD_T);

    for (int i = 0; i < 10; i++) step();
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
